// File: rtl/right_counter_items.sv
// rtl/right_counter_items.sv - right-wall counter column item exchange controller
// A press at a legal counter transfers items between the penguin's hand and that counter slot.
module right_counter_items (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        touchingRightWallFlag,
  input  logic [9:0]  nearestCounterX,
  input  logic [9:0]  nearestCounterY,
  input  logic        interact,
  input  logic        discard,
  output logic [2:0]  held_item,
  output logic [17:0] counter_items,
  output logic        busy,
  output logic        done,
  output logic        nack,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, DECODE, APPLY, WAIT_REL} state_t;

  state_t          state;
  logic            interact_q;
  logic [9:0]      x_q;
  logic [9:0]      y_q;
  logic            valid_q;
  logic [2:0]      idx_q;
  logic [5:0][2:0] slots;
  logic            press;
  logic            valid_c;
  logic [2:0]      idx_c;
  logic [2:0]      slot_s;

  assign press         = interact & ~interact_q;
  assign counter_items = slots;
  assign slot_s        = slots[idx_q];

  // Counter centres sit every 40 px starting at Y=140, all in the X=580 column.
  always_comb begin
    valid_c = 1'b0;
    idx_c   = 3'd0;
    case (y_q)
      10'd140: begin valid_c = 1'b1; idx_c = 3'd0; end
      10'd180: begin valid_c = 1'b1; idx_c = 3'd1; end
      10'd220: begin valid_c = 1'b1; idx_c = 3'd2; end
      10'd260: begin valid_c = 1'b1; idx_c = 3'd3; end
      10'd300: begin valid_c = 1'b1; idx_c = 3'd4; end
      10'd340: begin valid_c = 1'b1; idx_c = 3'd5; end
      default: begin valid_c = 1'b0; idx_c = 3'd0; end
    endcase
    if (x_q != 10'd580) begin
      valid_c = 1'b0;
      idx_c   = 3'd0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      interact_q <= 1'b1;
      x_q        <= 10'd0;
      y_q        <= 10'd0;
      valid_q    <= 1'b0;
      idx_q      <= 3'd0;
      held_item  <= 3'd0;
      slots      <= {3'd0, 3'd3, 3'd0, 3'd2, 3'd0, 3'd1};
      busy       <= 1'b0;
      done       <= 1'b0;
      nack       <= 1'b0;
      err        <= 1'b0;
    end else begin
      interact_q <= interact;
      done       <= 1'b0;
      nack       <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (press && touchingRightWallFlag) begin
            x_q   <= nearestCounterX;
            y_q   <= nearestCounterY;
            busy  <= 1'b1;
            state <= DECODE;
          end else if (press) begin
            state <= WAIT_REL;
          end else if (discard) begin
            held_item <= 3'd0;
          end
        end
        DECODE: begin
          valid_q <= valid_c;
          idx_q   <= idx_c;
          state   <= APPLY;
        end
        APPLY: begin
          busy  <= 1'b0;
          state <= WAIT_REL;
          if (!valid_q) begin
            err <= 1'b1;
          end else if (held_item == 3'd0 && slot_s == 3'd0) begin
            nack <= 1'b1;
          end else begin
            // Place, pick up and exchange all reduce to swapping hand and slot.
            slots[idx_q] <= held_item;
            held_item    <= slot_s;
            done         <= 1'b1;
          end
        end
        WAIT_REL: begin
          if (!interact) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_right_counter_items.sv
// tb/tb_right_counter_items.sv - directed self-checking bench for right_counter_items
module tb_right_counter_items;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        touchingRightWallFlag;
  logic [9:0]  nearestCounterX;
  logic [9:0]  nearestCounterY;
  logic        interact;
  logic        discard;
  logic [2:0]  held_item;
  logic [17:0] counter_items;
  logic        busy;
  logic        done;
  logic        nack;
  logic        err;

  int n_checks = 0;
  int n_fails  = 0;

  right_counter_items dut (
    .Clk                   (Clk),
    .Reset_n               (Reset_n),
    .touchingRightWallFlag (touchingRightWallFlag),
    .nearestCounterX       (nearestCounterX),
    .nearestCounterY       (nearestCounterY),
    .interact              (interact),
    .discard               (discard),
    .held_item             (held_item),
    .counter_items         (counter_items),
    .busy                  (busy),
    .done                  (done),
    .nack                  (nack),
    .err                   (err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One press transaction; coordinates and flag are scrambled after the latch.
  task automatic txn(input string tag, input logic [9:0] x, input logic [9:0] y,
                     input logic flag, input logic dsc, input int extra,
                     input logic [2:0] exp_held, input logic [17:0] exp_ctr,
                     input int exp_done, input int exp_nack, input int exp_err);
    int nd, nn, ne;
    nd = 0; nn = 0; ne = 0;
    @(negedge Clk);
    nearestCounterX       = x;
    nearestCounterY       = y;
    touchingRightWallFlag = flag;
    discard               = dsc;
    interact              = 1'b1;
    for (int i = 1; i <= 3 + extra; i++) begin
      @(negedge Clk);
      if (i == 1) begin
        nearestCounterX       = 10'd0;
        nearestCounterY       = 10'd999;
        touchingRightWallFlag = ~flag;
      end
      if (i <= 2) check({tag, "_busy"}, busy, flag);
      if (i == 3) check({tag, "_busy_end"}, busy, 1'b0);
      nd += done; nn += nack; ne += err;
    end
    interact = 1'b0;
    discard  = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      nd += done; nn += nack; ne += err;
    end
    check({tag, "_held"}, held_item, exp_held);
    check({tag, "_ctr"}, counter_items, exp_ctr);
    check({tag, "_done"}, nd, exp_done);
    check({tag, "_nack"}, nn, exp_nack);
    check({tag, "_err"}, ne, exp_err);
  endtask

  task automatic do_discard(input logic [2:0] exp_held, input logic [17:0] exp_ctr);
    @(negedge Clk);
    discard = 1'b1;
    @(negedge Clk);
    discard = 1'b0;
    check("discard_held", held_item, exp_held);
    check("discard_ctr", counter_items, exp_ctr);
  endtask

  initial begin
    int nd;
    Reset_n               = 1'b0;
    touchingRightWallFlag = 1'b0;
    nearestCounterX       = 10'd0;
    nearestCounterY       = 10'd0;
    interact              = 1'b0;
    discard               = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_held", held_item, 3'd0);
    check("rst_ctr", counter_items, 18'h03081);
    check("rst_pulses", {busy, done, nack, err}, 4'b0000);
    Reset_n = 1'b1;

    txn("pickup0",  10'd580, 10'd140, 1'b1, 1'b0, 0, 3'd1, 18'h03080, 1, 0, 0);
    txn("place1",   10'd580, 10'd180, 1'b1, 1'b0, 0, 3'd0, 18'h03088, 1, 0, 0);
    txn("pickup2",  10'd580, 10'd220, 1'b1, 1'b0, 0, 3'd2, 18'h03008, 1, 0, 0);
    txn("swap1",    10'd580, 10'd180, 1'b1, 1'b0, 0, 3'd1, 18'h03010, 1, 0, 0);
    txn("bad_y",    10'd580, 10'd160, 1'b1, 1'b0, 0, 3'd1, 18'h03010, 0, 0, 1);
    txn("bad_x",    10'd540, 10'd140, 1'b1, 1'b0, 0, 3'd1, 18'h03010, 0, 0, 1);
    txn("noflag",   10'd580, 10'd140, 1'b0, 1'b0, 0, 3'd1, 18'h03010, 0, 0, 0);
    do_discard(3'd0, 18'h03010);
    txn("empty5",   10'd580, 10'd340, 1'b1, 1'b0, 20, 3'd0, 18'h03010, 0, 1, 0);
    txn("pickup4",  10'd580, 10'd300, 1'b1, 1'b0, 0, 3'd3, 18'h00010, 1, 0, 0);
    do_discard(3'd0, 18'h00010);
    txn("pickup1",  10'd580, 10'd180, 1'b1, 1'b0, 0, 3'd2, 18'h00000, 1, 0, 0);
    txn("dsc_press", 10'd580, 10'd140, 1'b1, 1'b1, 0, 3'd0, 18'h00002, 1, 0, 0);

    // Reset while the transaction sits in APPLY.
    @(negedge Clk);
    nearestCounterX       = 10'd580;
    nearestCounterY       = 10'd140;
    touchingRightWallFlag = 1'b1;
    interact              = 1'b1;
    repeat (2) @(negedge Clk);
    check("apply_busy", busy, 1'b1);
    Reset_n = 1'b0;
    #1;
    check("arst_held", held_item, 3'd0);
    check("arst_ctr", counter_items, 18'h03081);
    check("arst_busy", busy, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;
    nd = 0;
    repeat (4) begin
      @(negedge Clk);
      nd += done;
    end
    interact = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      nd += done;
    end
    check("arst_nodone", nd, 0);
    check("arst_held2", held_item, 3'd0);
    check("arst_ctr2", counter_items, 18'h03081);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
